// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg
//   Shared constants for the GPIO interrupt controller:
//   - register indices decoded from address[4:2]
//   - default debounce length (consecutive stable cycles)
package gpio_irq_pkg;

   localparam logic [2:0] GPIO_IRQ_LEVEL   = 3'd0;
   localparam logic [2:0] GPIO_IRQ_PENDING = 3'd1;
   localparam logic [2:0] GPIO_IRQ_EN      = 3'd2;
   localparam logic [2:0] GPIO_IRQ_RISE    = 3'd3;
   localparam logic [2:0] GPIO_IRQ_FALL    = 3'd4;

   localparam int GPIO_IRQ_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/gpio_irq_ctrl_debounce.sv
// gpio_debounce
//   Single-pin input conditioner: two-flop synchronizer followed by an
//   optional debouncer (enabled by defining GPIO_IRQ_DEBOUNCE_EN).
//   With the debouncer, a new level is accepted only after the synchronized
//   input has differed from the accepted level for DEBOUNCE_CYCLES
//   consecutive cycles; any shorter excursion restarts the count.
//   Without it, dout is the synchronizer output.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   din   - raw pin value, asynchronous to clk
//   dout  - conditioned level
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("gpio_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic sync1_reg;
   logic sync2_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_reg;
   logic          deb_reg;

   // The count reaching DEBOUNCE_CYCLES is never stored: the final step
   // commits the new level and clears the counter in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         deb_reg <= 1'b0;
      end else if (sync2_reg == deb_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt_reg <= '0;
         deb_reg <= sync2_reg;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign dout = deb_reg;
`else
   assign dout = sync2_reg;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl
//   Conditions the GPIO block's raw pin values (synchronize, optionally
//   debounce), detects rising/falling edges, latches enabled edges into a
//   write-1-to-clear PENDING register and drives one registered level
//   interrupt irq = |(PENDING & IRQ_EN).
//   Debouncing is present only when GPIO_IRQ_DEBOUNCE_EN is defined.
// Registers (address[4:2]): 0 LEVEL (RO), 1 PENDING (RW1C), 2 IRQ_EN,
//   3 RISE_EN, 4 FALL_EN; 5..7 read 0, writes ignored.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   read, write - bus strobes; address[4:2] selects the register
//   write_data  - write payload, bits [WIDTH-1:0] used
//   read_data   - combinational read data, 0 when read is low
//   gpio_in     - raw pin values (asynchronous)
//   irq         - registered interrupt request
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter int WIDTH           = 20,
   parameter int DEBOUNCE_CYCLES = GPIO_IRQ_DEBOUNCE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   input  logic [WIDTH-1:0]  gpio_in,
   output logic              irq
);

   if (WIDTH < 1 || WIDTH > 31 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("gpio_irq_ctrl: WIDTH must be 1..31 and DEBOUNCE_CYCLES >= 1");
   end

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d_reg;
   logic [WIDTH-1:0] pending_reg;
   logic [WIDTH-1:0] irq_en_reg;
   logic [WIDTH-1:0] rise_en_reg;
   logic [WIDTH-1:0] fall_en_reg;
   logic             irq_reg;

   logic [2:0]       reg_idx;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] w1c;
   logic             unused_bits;

   gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb [WIDTH-1:0] (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (gpio_in),
      .dout (deb)
   );

   assign reg_idx     = address[4:2];
   assign wdata       = write_data[WIDTH-1:0];
   assign unused_bits = ^{address[31:5], address[1:0], write_data[31:WIDTH]};

   // deb_d holds last cycle's level, so one-cycle edge pulses fall out of
   // comparing it with the current level.
   assign edge_set = (deb & ~deb_d_reg & rise_en_reg) |
                     (~deb & deb_d_reg & fall_en_reg);
   assign w1c      = (write && reg_idx == GPIO_IRQ_PENDING) ? wdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_d_reg   <= '0;
         pending_reg <= '0;
         irq_en_reg  <= '0;
         rise_en_reg <= '0;
         fall_en_reg <= '0;
         irq_reg     <= 1'b0;
      end else begin
         deb_d_reg   <= deb;
         // Set is OR-ed after the clear so a coincident edge wins.
         pending_reg <= (pending_reg & ~w1c) | edge_set;
         irq_reg     <= |(pending_reg & irq_en_reg);
         if (write) begin
            case (reg_idx)
               GPIO_IRQ_EN:   irq_en_reg  <= wdata;
               GPIO_IRQ_RISE: rise_en_reg <= wdata;
               GPIO_IRQ_FALL: fall_en_reg <= wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      read_data = '0;
      if (read) begin
         case (reg_idx)
            GPIO_IRQ_LEVEL:   read_data = 32'(deb);
            GPIO_IRQ_PENDING: read_data = 32'(pending_reg);
            GPIO_IRQ_EN:      read_data = 32'(irq_en_reg);
            GPIO_IRQ_RISE:    read_data = 32'(rise_en_reg);
            GPIO_IRQ_FALL:    read_data = 32'(fall_en_reg);
            default:          read_data = '0;
         endcase
      end
   end

   assign irq = irq_reg;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed vectors and sequences
// with spec-derived constants, then randomized traffic compared against a
// behavioural model. Works with or without GPIO_IRQ_DEBOUNCE_EN.
module tb_gpio_irq_ctrl;

   localparam int W = 20;
   localparam logic [31:0] MASK = 32'h000F_FFFF;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif

   logic          clk;
   logic          rst_n;
   logic          read;
   logic          write;
   logic [31:0]   address;
   logic [31:0]   write_data;
   logic [31:0]   read_data;
   logic [W-1:0]  gpio_in;
   logic          irq;

   int checks = 0;
   int errors = 0;

   gpio_irq_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read      (read),
      .write     (write),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .gpio_in   (gpio_in),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // sync = pin value two edges old; with debouncing, the accepted level
   // flips once the last DB sync samples all disagree with it.
   logic [W-1:0] m_s1, m_s2, m_debd, m_pend, m_en, m_rise, m_fall;
   logic         m_irq;
   logic [W-1:0] m_level;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   logic [W-1:0] m_deb;
   logic [W-1:0] m_hist [0:DB];
   int           m_nhist;
   assign m_level = m_deb;
`else
   assign m_level = m_s2;
`endif

   always @(posedge clk or negedge rst_n) begin : model
      logic [W-1:0] lvl, set_v, clr_v;
      logic [2:0]   widx;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      logic [W-1:0] flip;
`endif
      if (!rst_n) begin
         m_s1 <= '0; m_s2 <= '0; m_debd <= '0; m_pend <= '0;
         m_en <= '0; m_rise <= '0; m_fall <= '0; m_irq <= 1'b0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
         m_deb <= '0; m_nhist <= 0;
`endif
      end else begin
         lvl   = m_level;
         widx  = address[4:2];
         clr_v = (write && widx == 3'd1) ? write_data[W-1:0] : '0;
         set_v = (lvl & ~m_debd & m_rise) | (~lvl & m_debd & m_fall);
         m_pend <= (m_pend & ~clr_v) | set_v;
         m_irq  <= |(m_pend & m_en);
         m_debd <= lvl;
         m_s1   <= gpio_in;
         m_s2   <= m_s1;
         if (write && widx == 3'd2) m_en   <= write_data[W-1:0];
         if (write && widx == 3'd3) m_rise <= write_data[W-1:0];
         if (write && widx == 3'd4) m_fall <= write_data[W-1:0];
`ifdef GPIO_IRQ_DEBOUNCE_EN
         flip = m_s2 ^ m_deb;
         for (int k = 0; k < DB - 1; k++) flip = flip & (m_hist[k] ^ m_deb);
         if (m_nhist >= DB - 1) m_deb <= m_deb ^ flip;
         m_hist[0] <= m_s2;
         for (int k = 1; k < DB; k++) m_hist[k] <= m_hist[k-1];
         if (m_nhist < DB) m_nhist <= m_nhist + 1;
`endif
      end
   end

   function automatic logic [31:0] model_read(input logic [2:0] idx);
      case (idx)
         3'd0: return 32'(m_level);
         3'd1: return 32'(m_pend);
         3'd2: return 32'(m_en);
         3'd3: return 32'(m_rise);
         3'd4: return 32'(m_fall);
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input bit quiet);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end else if (!quiet) begin
         $display("ok   %s: 0x%08h at %0t", name, act, $time);
      end
   endtask

   // One clock: wait for the falling edge, then compare irq with the model.
   task automatic tick();
      @(negedge clk);
      check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq}, 1'b1);
   endtask

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
      address    = {27'd0, idx, 2'b00};
      write_data = d;
      write      = 1'b1;
      $display("wr   reg%0d <= 0x%08h", idx, d);
      tick();
      write      = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [2:0] idx,
                           input logic [31:0] exp);
      address = {27'd0, idx, 2'b00};
      read    = 1'b1;
      #1;
      check(name, read_data, exp, 1'b0);
      read    = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [2:0]  idx;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [31:0] r, junk;
      logic [2:0]  ridx;
      int          hold;

      tbl[0]  = '{1'b0, 3'd1, 32'h0,         32'h0};
      tbl[1]  = '{1'b0, 3'd2, 32'h0,         32'h0};
      tbl[2]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0};
      tbl[3]  = '{1'b0, 3'd2, 32'h0,         32'h000F_FFFF};
      tbl[4]  = '{1'b1, 3'd2, 32'h0,         32'h0};
      tbl[5]  = '{1'b0, 3'd2, 32'h0,         32'h0};
      tbl[6]  = '{1'b1, 3'd3, 32'hA5A5_A5A5, 32'h0};
      tbl[7]  = '{1'b0, 3'd3, 32'h0,         32'h0005_A5A5};
      tbl[8]  = '{1'b1, 3'd4, 32'h1234_5678, 32'h0};
      tbl[9]  = '{1'b0, 3'd4, 32'h0,         32'h0004_5678};
      tbl[10] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
      tbl[11] = '{1'b0, 3'd5, 32'h0,         32'h0};
      tbl[12] = '{1'b1, 3'd0, 32'h0,         32'h0};
      tbl[13] = '{1'b0, 3'd0, 32'h0,         32'h000F_FFFF};
      tbl[14] = '{1'b1, 3'd3, 32'h0,         32'h0};
      tbl[15] = '{1'b1, 3'd4, 32'h0,         32'h0};

      read = 1'b0; write = 1'b0; address = '0; write_data = '0;
      gpio_in = W'(MASK);
      rst_n = 1'b0;
      repeat (3) tick();
      check("read_idle_zero", read_data, 32'h0, 1'b0);

      // Reset release with pins high: LEVEL ramps, nothing pends.
      rst_n = 1'b1;
      for (int k = 1; k <= DB + 2; k++) begin
         tick();
         rd_check("level_ramp", 3'd0, (k < DB + 2) ? 32'h0 : MASK);
      end
      rd_check("pend_after_rst", 3'd1, 32'h0);
      check("irq_after_rst", {31'd0, irq}, 32'h0, 1'b0);

      // Register table.
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].idx, tbl[i].data);
         else           rd_check($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].exp);
      end

      // Pin 3 rise -> PENDING then irq, with exact latency.
      gpio_in[3] = 1'b0;
      repeat (DB + 4) tick();
      bus_write(3'd3, 32'h8);
      bus_write(3'd2, 32'h8);
      gpio_in[3] = 1'b1;
      for (int k = 1; k <= DB + 3; k++) begin
         tick();
         rd_check("p3_pending", 3'd1, (k >= DB + 3) ? 32'h8 : 32'h0);
      end
      check("p3_irq_early", {31'd0, irq}, 32'h0, 1'b0);
      tick();
      check("p3_irq", {31'd0, irq}, 32'h1, 1'b0);

      // Pin 5 falling: short glitch filtered, full-length low latched.
      bus_write(3'd4, 32'h20);
      bus_write(3'd2, 32'h28);
`ifdef GPIO_IRQ_DEBOUNCE_EN
      gpio_in[5] = 1'b0;
      repeat (DB - 1) tick();
      gpio_in[5] = 1'b1;
      repeat (DB + 4) tick();
      rd_check("glitch_level", 3'd0, MASK);
      rd_check("glitch_pend", 3'd1, 32'h8);
`endif
      gpio_in[5] = 1'b0;
      repeat ((DB > 0) ? DB : 1) tick();
      gpio_in[5] = 1'b1;
      repeat (DB + 4) tick();
      rd_check("p5_pend", 3'd1, 32'h28);

      // W1C of bit 3 keeps bit 5 and irq; clearing bit 5 drops irq an edge later.
      bus_write(3'd1, 32'h8);
      rd_check("w1c_bit3", 3'd1, 32'h20);
      tick();
      check("irq_hold", {31'd0, irq}, 32'h1, 1'b0);
      bus_write(3'd1, 32'h20);
      rd_check("w1c_bit5", 3'd1, 32'h0);
      check("irq_lag", {31'd0, irq}, 32'h1, 1'b0);
      tick();
      check("irq_drop", {31'd0, irq}, 32'h0, 1'b0);

      // Rise on pin 3 coincident with W1C of bit 3: set wins.
      gpio_in[3] = 1'b0;
      repeat (DB + 4) tick();
      bus_write(3'd1, MASK);
      gpio_in[3] = 1'b1;
      repeat (DB + 2) tick();
      bus_write(3'd1, 32'h8);
      rd_check("set_wins", 3'd1, 32'h8);

      // Reset mid-debounce: count discarded, ramp restarts from zero.
      gpio_in[0] = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check("rst_irq", {31'd0, irq}, 32'h0, 1'b0);
      rd_check("rst_pend", 3'd1, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= DB + 2; k++) begin
         tick();
         rd_check("rst_ramp", 3'd0, (k < DB + 2) ? 32'h0 : (MASK & ~32'h1));
      end

      // Randomized traffic against the model.
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0) begin
            gpio_in = W'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         junk = $urandom;
         ridx = 3'($urandom_range(0, 7));
         write_data = $urandom;
         write = ($urandom_range(0, 3) == 0);
         address = {junk[31:5], ridx, junk[1:0]};
         if (write) $display("wr   reg%0d <= 0x%08h (random)", ridx, write_data);
         read = ($urandom_range(0, 3) != 0);
         #1;
         r = read ? model_read(ridx) : 32'h0;
         check($sformatf("rand_rd%0d", ridx), read_data, r, 1'b0);
         read = 1'b0;
         tick();
         write = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

Input-conditioning and interrupt stage sitting directly downstream of the GPIO pin block. It consumes the raw per-pin input values the GPIO block produces, synchronises and debounces them, detects rising/falling edges, latches them into a write-1-to-clear pending register, and raises one level interrupt line to the core. It is memory-mapped on the same simple read/write peripheral bus as the GPIO block.

## Interface
- `WIDTH`, 20: number of GPIO pins monitored, from 1 to 31.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a new level; must be ≥ 1.
- `clk` input 1: the only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `read` input 1: bus read strobe.
- `write` input 1: bus write strobe, single-cycle.
- `address` input 32: only `address[4:2]` is decoded.
- `write_data` input 32: write payload, bits `[WIDTH-1:0]` used.
- `read_data` output 32: combinational; the selected register when `read`=1, otherwise 0. Unused upper bits read 0.
- `gpio_in` input WIDTH: raw pin values from the GPIO block's data output; asynchronous to `clk`.
- `irq` output 1: registered; `|(pending & irq_en)`.

## Operation
- Register map, by `address[4:2]`:
  - 0 LEVEL: RO, debounced levels.
  - 1 PENDING: RW1C.
  - 2 IRQ_EN: RW.
  - 3 RISE_EN: RW.
  - 4 FALL_EN: RW.
  - 5–7: read 0, writes ignored.
- Per-pin pipeline: two-flop synchronizer → debouncer → edge detector.
- Debouncer per pin:
  - Holds a counter of `$clog2(DEBOUNCE_CYCLES+1)` bits and a debounced level `deb`.
  - When `sync == deb`, the counter clears to 0.
  - When `sync != deb`, the counter increments each cycle.
  - If it would reach `DEBOUNCE_CYCLES`, the update instead sets `deb <= sync` and clears the counter to 0.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never changes `deb`.
- Edge detection:
  - `rise = deb & ~deb_d`, `fall = ~deb & deb_d`, where `deb_d` is `deb` delayed by one register.
  - `pending[i]` sets on `(rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])`.
- PENDING write: each bit written 1 is cleared; bits written 0 are unchanged.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- Writing IRQ_EN does not alter PENDING. `irq` follows the masked OR one cycle later.
- Reset values (asynchronous, immediate):
  - Cleared to 0: synchronizer flops, `deb`, `deb_d`, counters, PENDING, IRQ_EN, RISE_EN, FALL_EN, `irq`.
  - `read_data` is 0 unless `read` is asserted.
  - No edge is generated on reset release, even when pins idle high; the debouncer ramps `deb` to 1 with `rise` visible, but `RISE_EN`=0 at that point.
- Reset asserted mid-debounce: the count is discarded. After release, counting restarts from 0.

## Timing
- Pin change sampled at clock edge E0 → `sync` changes at E1 → `deb` changes at E1+`DEBOUNCE_CYCLES` → `pending` sets one edge later → `irq` asserts one edge after that.
- Total pin-to-`irq` latency: `DEBOUNCE_CYCLES` + 3 edges after sampling (7 edges at default).
- Register writes take effect on the clock edge where `write`=1. Reads have zero latency and reflect register contents before that edge.
- A W1C of the only pending bit drops `irq` one edge after the write edge.

## Configuration
- `GPIO_IRQ_DEBOUNCE_EN` defined: debouncer instantiated as described.
- `GPIO_IRQ_DEBOUNCE_EN` undefined: `deb = sync` directly, no counters exist, and `DEBOUNCE_CYCLES` is ignored. Pin-to-`irq` latency becomes 3 edges after sampling. All other behaviour is identical.

## Structure
- Shared package `gpio_irq_pkg`:
  - register index constants: `GPIO_IRQ_LEVEL`=0, `GPIO_IRQ_PENDING`=1, `GPIO_IRQ_EN`=2, `GPIO_IRQ_RISE`=3, `GPIO_IRQ_FALL`=4.
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `gpio_debounce`: one per pin via instance array; contains the synchronizer plus debouncer; ports `clk`, `rst_n`, `din`, `dout`.
- The top level holds the edge detection, registers, bus decode and `irq`.

## Test plan
- Reset with `gpio_in`=all-ones, then release: all registers read 0, `irq`=0 and stays 0; LEVEL reads `0x000FFFFF` after 2+4 edges.
- RISE_EN=1, IRQ_EN=1 on pin 3; drive pin 3 high at E0: PENDING reads `0x8` from E0+6 and `irq`=1 at E0+7.
- Pin 5 with FALL_EN set: a 3-cycle low glitch leaves LEVEL/PENDING unchanged; a 4-cycle low sets PENDING bit 5.
- Pending bits 3 and 5 set, write PENDING=`0x8`: PENDING reads `0x20`, and `irq` stays 1 if IRQ_EN bit 5 is set.
- A new rise on pin 3 in the same cycle as a W1C of bit 3: bit 3 remains 1.
- Assert `rst_n` low mid-debounce, then release: no LEVEL change until a fresh 4 stable cycles. Build without `GPIO_IRQ_DEBOUNCE_EN`: pin-to-`irq` is 3 edges.
